// File: rtl/nand_pkg.sv
// Shared NAND flash bus definitions: write_type encodings and default
// timing constants used by both the write and read byte sequencers.
package nand_pkg;

    typedef enum logic [1:0] {
        NF_DATA = 2'b00,
        NF_CMD  = 2'b01,
        NF_ADDR = 2'b10
    } nf_type_t;

    // Default timing in clk cycles at 100 MHz
    localparam int TWP  = 3;
    localparam int TWC  = 6;
    localparam int TRP  = 3;
    localparam int TRC  = 6;
    localparam int TREA = 2;
    localparam int TWB  = 10;

endpackage

// File: rtl/nf_sync2.sv
// Two-flop synchronizer for asynchronous flash status inputs such as R/B#.
module nf_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/write_byte.sv
// One NAND flash write cycle (command, address or data byte) with optional
// tWB delay and R/B# ready wait so program/erase complete in one handshake.
//
// state   | meaning
// IDLE    | bus released, waiting for write_en
// WE_LOW  | WE# low, byte and CLE/ALE driven
// WE_HIGH | WE# high, byte still held for tDH/tCLH/tALH
// WAIT_WB | bus released, waiting tWB before looking at R/B#
// WAIT_RB | waiting for synchronized R/B# high or timeout
module write_byte #(
    parameter int TWP        = nand_pkg::TWP,
    parameter int TWC        = nand_pkg::TWC,
    parameter int TWB        = nand_pkg::TWB,
    parameter int RB_TIMEOUT = 50000,
    parameter int RBW        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_en,
    input  logic [1:0] write_type,
    input  logic [7:0] write_data,
    input  logic       wait_rb,
    output logic       ack,
    output logic       busy,
    output logic       rb_timeout,
    output logic [7:0] nf_io_out,
    output logic       nf_io_oe,
    output logic       nf_we_n,
    output logic       nf_cle,
    output logic       nf_ale,
    input  logic       nf_rb_n
);

    import nand_pkg::*;

    if (TWP < 1 || TWP > 256) begin : g_bad_twp
        $error("write_byte: TWP must be in 1..256");
    end
    if (TWC <= TWP || TWC - TWP > 256) begin : g_bad_twc
        $error("write_byte: TWC must exceed TWP by 1..256");
    end
    if (TWB < 1 || TWB > 256) begin : g_bad_twb
        $error("write_byte: TWB must be in 1..256");
    end
    if (RBW < 1 || RBW > 31 || RB_TIMEOUT < 1 || RB_TIMEOUT > (1 << RBW)) begin : g_bad_rb
        $error("write_byte: RB_TIMEOUT must be in 1..2**RBW");
    end

    // Counters are loaded with (duration - 1) and expire when they reach zero
    localparam logic [7:0]     TWP_LD = 8'(TWP - 1);
    localparam logic [7:0]     TWH_LD = 8'(TWC - TWP - 1);
    localparam logic [7:0]     TWB_LD = 8'(TWB - 1);
    localparam logic [RBW-1:0] RB_LD  = RBW'(RB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WE_LOW, WE_HIGH, WAIT_WB, WAIT_RB
    } state_t;

    state_t         state, state_nx;
    logic [7:0]     cnt, cnt_nx;
    logic [RBW-1:0] rb_cnt, rb_cnt_nx;
    logic           wait_q, wait_nx;
    logic           ack_nx, busy_nx, rb_timeout_nx;
    logic [7:0]     io_out_nx;
    logic           oe_nx, we_n_nx, cle_nx, ale_nx;
    logic           rb_ready;

    nf_sync2 #(.RST_VAL(1'b0)) u_rb_sync (
        .clk (clk),
        .rst (rst),
        .d   (nf_rb_n),
        .q   (rb_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rb_cnt     <= '0;
            wait_q     <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            rb_timeout <= 1'b0;
            nf_io_out  <= '0;
            nf_io_oe   <= 1'b0;
            nf_we_n    <= 1'b1;
            nf_cle     <= 1'b0;
            nf_ale     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rb_cnt     <= rb_cnt_nx;
            wait_q     <= wait_nx;
            ack        <= ack_nx;
            busy       <= busy_nx;
            rb_timeout <= rb_timeout_nx;
            nf_io_out  <= io_out_nx;
            nf_io_oe   <= oe_nx;
            nf_we_n    <= we_n_nx;
            nf_cle     <= cle_nx;
            nf_ale     <= ale_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        rb_cnt_nx     = rb_cnt;
        wait_nx       = wait_q;
        ack_nx        = 1'b0;
        busy_nx       = busy;
        rb_timeout_nx = rb_timeout;
        io_out_nx     = nf_io_out;
        oe_nx         = nf_io_oe;
        we_n_nx       = nf_we_n;
        cle_nx        = nf_cle;
        ale_nx        = nf_ale;

        unique case (state)
            IDLE: begin
                if (write_en) begin
                    io_out_nx     = write_data;
                    cle_nx        = (write_type == NF_CMD);
                    ale_nx        = (write_type == NF_ADDR);
                    wait_nx       = wait_rb;
                    rb_timeout_nx = 1'b0;
                    we_n_nx       = 1'b0;
                    oe_nx         = 1'b1;
                    busy_nx       = 1'b1;
                    cnt_nx        = TWP_LD;
                    state_nx      = WE_LOW;
                end
            end
            WE_LOW: begin
                if (cnt == '0) begin
                    we_n_nx  = 1'b1;
                    cnt_nx   = TWH_LD;
                    state_nx = WE_HIGH;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            WE_HIGH: begin
                if (cnt == '0) begin
                    oe_nx  = 1'b0;
                    cle_nx = 1'b0;
                    ale_nx = 1'b0;
                    if (wait_q) begin
                        cnt_nx   = TWB_LD;
                        state_nx = WAIT_WB;
                    end else begin
                        ack_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            WAIT_WB: begin
                if (cnt == '0) begin
                    rb_cnt_nx = RB_LD;
                    state_nx  = WAIT_RB;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            WAIT_RB: begin
                if (rb_ready) begin
                    ack_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (rb_cnt == '0) begin
                    ack_nx        = 1'b1;
                    rb_timeout_nx = 1'b1;
                    busy_nx       = 1'b0;
                    state_nx      = IDLE;
                end else begin
                    rb_cnt_nx = rb_cnt - RBW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_write_byte.sv
// Bench for write_byte: per-write expectations queued at stimulus time and
// checked against bus activity measured up to each ack.
module tb_write_byte;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_en = 1'b0;
    logic [1:0] write_type = 2'b00;
    logic [7:0] write_data = 8'h00;
    logic       wait_rb = 1'b0;
    logic       nf_rb_n = 1'b0;

    logic       ack_a, busy_a, to_a, oe_a, we_n_a, cle_a, ale_a;
    logic [7:0] io_a;
    logic       ack_b, busy_b, to_b, oe_b, we_n_b, cle_b, ale_b;
    logic [7:0] io_b;

    always #5 clk = ~clk;

    write_byte #(.TWP(3), .TWC(6), .TWB(10), .RB_TIMEOUT(60), .RBW(16)) dut_a (
        .clk(clk), .rst(rst), .write_en(write_en), .write_type(write_type),
        .write_data(write_data), .wait_rb(wait_rb), .ack(ack_a), .busy(busy_a),
        .rb_timeout(to_a), .nf_io_out(io_a), .nf_io_oe(oe_a), .nf_we_n(we_n_a),
        .nf_cle(cle_a), .nf_ale(ale_a), .nf_rb_n(nf_rb_n)
    );

    // Short R/B# timeout instance, checked only in the timeout scenario
    write_byte #(.TWP(3), .TWC(6), .TWB(10), .RB_TIMEOUT(20), .RBW(8)) dut_b (
        .clk(clk), .rst(rst), .write_en(write_en), .write_type(write_type),
        .write_data(write_data), .wait_rb(wait_rb), .ack(ack_b), .busy(busy_b),
        .rb_timeout(to_b), .nf_io_out(io_b), .nf_io_oe(oe_b), .nf_we_n(we_n_b),
        .nf_cle(cle_b), .nf_ale(ale_b), .nf_rb_n(nf_rb_n)
    );

    typedef struct {
        logic [7:0] data;
        bit         cle;
        bit         ale;
        bit         to;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_total = 0, n_bad = 0, n_ack = 0, exp_acks = 0;
    int   c_oe, c_we, c_cle, c_ale, c_stray;
    logic [7:0] io_we;
    logic prev_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [7:0] d, input bit cle, input bit ale, input bit to);
        sb.push_back('{d, cle, ale, to});
        exp_acks++;
    endtask

    // Accumulate bus activity of dut_a; each ack closes one transaction
    always @(negedge clk) begin
        if (rst) begin
            c_oe = 0; c_we = 0; c_cle = 0; c_ale = 0; c_stray = 0;
            io_we = 8'h00; prev_ack = 1'b0;
        end else begin
            if (oe_a) c_oe++;
            if (!we_n_a) begin
                c_we++;
                io_we = io_a;
            end
            if (cle_a) c_cle++;
            if (ale_a) c_ale++;
            if ((cle_a || ale_a) && !oe_a) c_stray++;
            if (ack_a) begin
                n_ack++;
                chk("ack_pulse", prev_ack, 0);
                chk("sb_pop", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_data", io_we, e.data);
                    chk("sb_io_hold", io_a, e.data);
                    chk("sb_we_width", c_we, 3);
                    chk("sb_oe_width", c_oe, 6);
                    chk("sb_cle", c_cle, e.cle ? 6 : 0);
                    chk("sb_ale", c_ale, e.ale ? 6 : 0);
                    chk("sb_stray", c_stray, 0);
                    chk("sb_rb_timeout", to_a, e.to);
                end
                c_oe = 0; c_we = 0; c_cle = 0; c_ale = 0; c_stray = 0;
            end
            prev_ack = ack_a;
        end
    end

    // Returns at the sample point right after the accepting edge
    task automatic send(input logic [1:0] t, input logic [7:0] d, input logic w);
        @(negedge clk);
        write_en = 1'b1; write_type = t; write_data = d; wait_rb = w;
        @(negedge clk);
        write_en = 1'b0;
        chk("accept_busy", busy_a, 1);
    endtask

    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        while (!ack_a && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        chk("ack_wait", ack_a, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad_hold, i;

        repeat (3) @(negedge clk);
        chk("reset_state", {we_n_a, oe_a, io_a, cle_a, ale_a, ack_a, busy_a, to_a},
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        nf_rb_n = 1'b1;
        repeat (2) @(negedge clk);

        // Data byte, cycle-exact bus trace
        expect_wr(8'hA5, 0, 0, 0);
        send(2'b00, 8'hA5, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("t1_we_n", we_n_a, (k < 3) ? 1'b0 : 1'b1);
            chk("t1_oe", oe_a, (k < 6) ? 1'b1 : 1'b0);
            if (k < 6) chk("t1_io", io_a, 8'hA5);
            chk("t1_ack", ack_a, (k == 6) ? 1'b1 : 1'b0);
            chk("t1_busy", busy_a, (k < 6) ? 1'b1 : 1'b0);
            @(negedge clk);
        end

        // Command with input churn while busy, then address
        expect_wr(8'h70, 1, 0, 0);
        send(2'b01, 8'h70, 1'b0);
        write_en = 1'b1; write_type = 2'b10; write_data = 8'hFF; wait_rb = 1'b1;
        repeat (2) @(negedge clk);
        write_en = 1'b0; wait_rb = 1'b0;
        wait_ack(20, lat);
        expect_wr(8'h12, 0, 1, 0);
        send(2'b10, 8'h12, 1'b0);
        wait_ack(20, lat);

        // Program-style wait for R/B# ready
        nf_rb_n = 1'b0;
        expect_wr(8'h10, 1, 0, 0);
        send(2'b01, 8'h10, 1'b1);
        repeat (6) @(negedge clk);
        chk("t3_release", {oe_a, cle_a}, 2'b00);
        bad_hold = 0;
        repeat (40) begin
            if (ack_a || !busy_a) bad_hold++;
            @(negedge clk);
        end
        chk("t3_hold", bad_hold, 0);
        nf_rb_n = 1'b1;
        wait_ack(10, lat);
        chk("t3_rb_latency", (lat >= 2 && lat <= 3), 1);

        // R/B# stuck low: timeout on both instances, then cleared by next request
        nf_rb_n = 1'b0;
        expect_wr(8'h10, 1, 0, 1);
        send(2'b01, 8'h10, 1'b1);
        i = 0;
        while (!ack_b && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("t4_b_latency", i, 36);
        chk("t4_b_timeout", to_b, 1);
        chk("t4_b_busy", busy_b, 0);
        wait_ack(100, lat);
        chk("t4_a_latency", i + lat, 76);
        expect_wr(8'h33, 0, 0, 0);
        send(2'b00, 8'h33, 1'b0);
        chk("t4_clr_a", to_a, 0);
        chk("t4_clr_b", to_b, 0);
        wait_ack(20, lat);

        // Back-to-back with write_en held high
        nf_rb_n = 1'b1;
        expect_wr(8'h01, 0, 0, 0);
        expect_wr(8'h02, 0, 0, 0);
        @(negedge clk);
        write_en = 1'b1; write_type = 2'b00; write_data = 8'h01; wait_rb = 1'b0;
        @(negedge clk);
        i = 0;
        while (!ack_a && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("t5_first_ack", ack_a, 1);
        write_data = 8'h02;
        @(negedge clk);
        chk("t5_b2b_we_n", we_n_a, 0);
        chk("t5_b2b_busy", busy_a, 1);
        write_en = 1'b0;
        wait_ack(20, lat);

        // Reset abort in WE_LOW, then a normal write
        send(2'b00, 8'h5A, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_abort", {we_n_a, oe_a, busy_a, ack_a}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        expect_wr(8'hC3, 0, 0, 0);
        send(2'b00, 8'hC3, 1'b0);
        wait_ack(20, lat);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("ack_count", n_ack, exp_acks);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
